// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: FSM state encoding, response codes and the
// register-index-to-byte-address helper used by master and slave.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Registers are 32-bit words, so index N lives at base + 4*N.
    function automatic logic [31:0] reg_to_addr(input logic [31:0] base,
                                                input logic [7:0]  idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/axi_lite_reg_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_reg_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// Loadable down-counter. expired flags the last enabled cycle of the window,
// so a load of N allows exactly N enabled cycles. A load of 0 never expires.
module axi_lite_timeout_cnt #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down while enabled, saturating at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == WIDTH'(1));
endmodule

// File: rtl/axi_lite_reg_master.sv
// Register-command to AXI4-Lite master, one transaction outstanding.
// Handshakes: every channel transfers on a cycle where valid && ready; a
// valid, once raised, holds itself and its payload until that cycle (the
// timeout escape is the only exception and deliberately breaks AXI rules).
module axi_lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int          C_M_AXI_DATA_WIDTH  = 32,
    parameter int          C_M_AXI_ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR           = 32'h0,
    parameter int          NUMBER_OF_REGISTERS = 6,
    parameter int          TIMEOUT_CYCLES      = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [7:0]                    cmd_reg,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic                          busy,
    output state_t                        dbg_state,
    axi_lite_reg_master_if.master         m_axi
);
    localparam int          AW   = C_M_AXI_ADDR_WIDTH;
    localparam int          DW   = C_M_AXI_DATA_WIDTH;
    localparam int          TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [31:0] NREG = 32'(NUMBER_OF_REGISTERS);

    state_t          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic            busy_q, busy_d;

    logic            accept;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic            to_load, to_en, to_expired, take_timeout;
    logic [31:0]     full_addr;

    assign accept = cmd_valid && cmd_ready_q;
    assign aw_hs  = awvalid_q && m_axi.awready;
    assign w_hs   = wvalid_q  && m_axi.wready;
    assign b_hs   = bready_q  && m_axi.bvalid;
    assign ar_hs  = arvalid_q && m_axi.arready;
    assign r_hs   = rready_q  && m_axi.rvalid;

    // The counter runs only in states that wait on the slave.
    assign to_en = (state_q == WRITE) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR) || (state_q == RD_DATA);

    axi_lite_timeout_cnt #(.WIDTH(TO_W)) u_timeout (
        .clk      (M_AXI_ACLK),
        .rst_n    (M_AXI_ARESETN),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT_CYCLES)),
        .en       (to_en),
        .expired  (to_expired)
    );

    // Next-state and next-output logic; a handshake in the expiry cycle wins.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        to_load       = 1'b0;
        take_timeout  = 1'b0;
        full_addr     = reg_to_addr(BASE_ADDR, cmd_reg);

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = full_addr[AW-1:0];
                    wdata_d     = cmd_wdata;
                    to_load     = 1'b1;
                    if ({24'd0, cmd_reg} >= NREG) begin
                        // Out-of-range index: answer locally, never touch the bus.
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_resp_d    = RESP_SLVERR;
                        rsp_rdata_d   = '0;
                        rsp_timeout_d = 1'b0;
                    end else if (cmd_write) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                awvalid_d = awvalid_q && !aw_hs;
                wvalid_d  = wvalid_q  && !w_hs;
                to_load   = aw_hs || w_hs;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (to_expired && !aw_hs && !w_hs) begin
                    take_timeout = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    to_load       = 1'b1;
                    bready_d      = 1'b0;
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else if (to_expired) begin
                    take_timeout = 1'b1;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    to_load   = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (to_expired) begin
                    take_timeout = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    to_load       = 1'b1;
                    rready_d      = 1'b0;
                    state_d       = DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.rresp;
                    rsp_rdata_d   = m_axi.rdata;
                    rsp_timeout_d = 1'b0;
                end else if (to_expired) begin
                    take_timeout = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Debug escape: abandon the bus and report a timed-out completion.
        if (take_timeout) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            state_d       = DONE;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = RESP_DECERR;
            rsp_rdata_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // All FSM state and registered outputs; reset drops everything at once.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
endmodule

// File: doc/axi_lite_reg_master.md
Name: axi_lite_reg_master

Overview:
- Synthesizable AXI4-Lite master that turns single register commands (read/write by register number) into AXI4-Lite transactions.
- Sits directly upstream of axi_slave_impl and drives its S_AXI_* port set.
- Used by on-chip sequencers and the verification bench to access the slave's register bank without hand-written AXI bus wiggling.
- One outstanding transaction at a time; completion is reported on a response channel.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 10, address width; must match the downstream slave.
- BASE_ADDR, 0, byte address of register 0.
- NUMBER_OF_REGISTERS, 6, highest valid register index + 1; indices at or above this are rejected.
- TIMEOUT_CYCLES, 256, max cycles waiting on any single AXI handshake; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_reg  in  8  register number.
- cmd_wdata  in  DATA  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 for a rejected index.
- rsp_timeout  out  1  completion caused by timeout.
- busy  out  1  transaction in progress.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset: all *VALID/*READY = 0, cmd_ready = 0, rsp_* = 0, busy = 0, state IDLE; timeout counter 0. Reset mid-transaction drops everything immediately.
- Address: AWADDR/ARADDR = BASE_ADDR + (cmd_reg << 2), truncated to ADDR width. AWPROT = ARPROT = 3'b000. WSTRB = all ones.
- FSM states: IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch cmd_write, address and wdata.
  - If cmd_reg >= NUMBER_OF_REGISTERS, go to DONE with rsp_resp = 2'b10 and issue no bus activity.
  - Otherwise go to WRITE or RD_ADDR.
- WRITE:
  - AWVALID and WVALID assert on the first cycle after accept.
  - Each VALID drops independently on its own handshake; AW and W may complete in either order or the same cycle.
  - Go to WR_RESP once both have completed.
- WR_RESP: BREADY = 1; on BVALID, latch BRESP and go to DONE.
- RD_ADDR: ARVALID = 1; on ARREADY go to RD_DATA.
- RD_DATA: RREADY = 1; on RVALID, latch RDATA and RRESP and go to DONE.
- DONE: rsp_valid = 1 for exactly one cycle, then IDLE. cmd_ready stays 0 in DONE, so a new command is accepted no earlier than the cycle after rsp_valid.
- Latency, zero-wait slave: write accept → rsp_valid = 4 cycles; read = 4 cycles.
- Payload and VALID stability: once asserted, AWADDR, WDATA and ARADDR stay stable until their handshake, and no VALID deasserts before READY, except on timeout.
- busy = state != IDLE.
- Timeout:
  - Counter clears on entry to each wait state and on every handshake.
  - If it reaches TIMEOUT_CYCLES: drop all VALID/READY, go to DONE with rsp_timeout = 1, rsp_resp = 2'b11, rsp_rdata = 0.
  - This is a debug escape and is documented as an AXI protocol violation.
- Simultaneous BVALID and timeout expiry: the handshake wins.

Decomposition:
- Shared package axi_lite_pkg holds:
  - state encoding;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - the register-index-to-address function.
- One sub-module, axi_lite_timeout_cnt: a loadable down-counter with an expire flag, also reusable by the slave side.

Test Plan:
- Write reg 2 = 0xDEADBEEF, zero-wait slave → AWADDR = 0x008, WDATA = 0xDEADBEEF, rsp_valid 4 cycles after accept, rsp_resp = 0, rsp_rdata = 0.
- Read back reg 2 → ARADDR = 0x008, rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
- Slave holds WREADY low 5 cycles while AWREADY is immediate → AWVALID drops after 1 cycle, WVALID held with stable data, exactly one B handshake, rsp_valid once.
- cmd_reg = 6 with NUMBER_OF_REGISTERS = 6 → no *VALID ever asserted, rsp_resp = 2'b10 on the cycle after accept.
- ARREADY tied low, TIMEOUT_CYCLES = 16 → ARVALID drops after 16 cycles, rsp_timeout = 1, rsp_resp = 2'b11, next command accepted.
- Assert M_AXI_ARESETN low during WR_RESP → all outputs 0 asynchronously; after release, a read of reg 0 completes normally.
